muldiv_scheduler: RTL
=====================

Name: muldiv_scheduler

Overview:
- Sequences the shared multi-cycle multiply/divide unit for the single-cycle processor.
- Detects R-type mul/div at the current PC, stalls PC and register writes, and latches operands and destination register.
- Issues a one-cycle start pulse to the unit, waits for ready (with timeout), then drives exactly one register-file writeback cycle: either the result to rd, or an exception code to $r30.

Parameters:
- MULT_OP, 5'b00110, ALUop field (instr[6:2]) for mul.
- DIV_OP, 5'b00111, ALUop field for div.
- TIMEOUT, 40, max WAIT cycles before forced exception; must be at least 2.
- STATUS_MUL, 32'd4, $r30 value on mul exception or timeout.
- STATUS_DIV, 32'd5, $r30 value on div exception or timeout.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- instruction  in  32  instruction at current PC; opcode [31:27], rd [26:22], ALUop [6:2].
- data_readRegA  in  32  rs value from the register file.
- data_readRegB  in  32  rt value from the register file.
- unit_result  in  32  mul/div unit result.
- unit_rdy  in  1  unit result valid (single-cycle pulse).
- unit_exception  in  1  overflow / divide-by-zero flag, valid with unit_rdy.
- ctrl_MULT  out  1  one-cycle mul start pulse.
- ctrl_DIV  out  1  one-cycle div start pulse.
- unit_operandA  out  32  latched rs.
- unit_operandB  out  32  latched rt.
- stall  out  1  freeze PC and suppress datapath register write.
- busy  out  1  unit in use (state ≠ IDLE).
- wb_en  out  1  scheduler register-file write enable.
- wb_reg  out  5  writeback destination.
- wb_data  out  32  writeback value.

Behaviour:
- Detect: opcode == 5'b00000 and ALUop ∈ {MULT_OP, DIV_OP}. Only evaluated in IDLE.
- States: IDLE, ISSUE, WAIT, DONE. Reset state is IDLE.
- IDLE
  - On detect: stall=1 combinationally in the same cycle.
  - Latch data_readRegA/B into unit_operandA/B, rd, and is_div (ALUop == DIV_OP).
  - Clear the timeout counter; next state ISSUE.
  - Otherwise stall=0 and remain in IDLE.
- ISSUE (exactly 1 cycle)
  - ctrl_MULT = ~is_div, ctrl_DIV = is_div; both driven from registered state, never both high.
  - stall=1; unit_rdy is ignored in this cycle. Next state WAIT.
- WAIT
  - stall=1; counter increments each cycle.
  - On unit_rdy: capture unit_result and unit_exception; next state DONE.
  - If counter reaches TIMEOUT-1 without unit_rdy: force exception=1; next state DONE.
  - unit_rdy on the same cycle as the timeout takes priority (the result is used).
- DONE (exactly 1 cycle)
  - stall=0, so the PC advances at this edge.
  - No exception: wb_en = (rd ≠ 0), wb_reg = rd, wb_data = captured result.
  - Exception: wb_en=1, wb_reg=5'd30, wb_data = is_div ? STATUS_DIV : STATUS_MUL.
  - Next state IDLE. Detect is not evaluated in DONE, so the same instruction is never re-issued.
- Outside DONE: wb_en=0, wb_reg=0, wb_data=0.
- Operand registers hold their values from the latch until the next detect.
- busy=1 in ISSUE, WAIT and DONE.
- Reset (async, any state): state=IDLE; every output 0; operand, rd, counter and capture registers cleared. Any in-flight operation is abandoned and a late unit_rdy is ignored.
- Back-to-back mul/div: the second is detected in the IDLE cycle after DONE.
- Minimum latency from detect to writeback: 4 cycles (IDLE, ISSUE, WAIT with rdy, DONE).

Test Plan:
- mul r3, r1, r2 with r1=7, r2=6; unit_rdy 5 cycles after ctrl_MULT -> ctrl_MULT high exactly 1 cycle, ctrl_DIV never high; stall high from detect through WAIT; DONE: wb_en=1, wb_reg=3, wb_data=42, stall=0.
- div r4, r1, r2 with r2=0; unit_rdy with unit_exception=1 -> ctrl_DIV pulse; DONE: wb_reg=30, wb_data=5; r4 not written.
- mul with the unit never asserting rdy, TIMEOUT=40 -> DONE after 40 WAIT cycles: wb_reg=30, wb_data=4; stall deasserts; returns to IDLE.
- mul with rd=0, result 99 -> DONE: wb_en=0, stall=0, no write.
- Reset asserted low during WAIT, then unit_rdy pulses after release -> all outputs 0 immediately; stays IDLE; no wb_en; non-mul/div instructions then see stall=0.
- add (ALUop 00000) followed by back-to-back mul, div -> add: no stall; mul completes DONE, next cycle div detected, two separate ctrl pulses, two writebacks in order.

Source files
------------

// File: rtl/muldiv_scheduler_if.sv
// Bundle between the core, the shared mul/div unit and the scheduler.
// master = scheduler side, slave = core/unit side.
interface muldiv_scheduler_if;
  logic [31:0] instruction;
  logic [31:0] data_readRegA;
  logic [31:0] data_readRegB;
  logic [31:0] unit_result;
  logic        unit_rdy;
  logic        unit_exception;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] unit_operandA;
  logic [31:0] unit_operandB;
  logic        stall;
  logic        busy;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;

  modport master (
    input  instruction, data_readRegA, data_readRegB, unit_result, unit_rdy, unit_exception,
    output ctrl_MULT, ctrl_DIV, unit_operandA, unit_operandB, stall, busy, wb_en, wb_reg, wb_data
  );

  modport slave (
    output instruction, data_readRegA, data_readRegB, unit_result, unit_rdy, unit_exception,
    input  ctrl_MULT, ctrl_DIV, unit_operandA, unit_operandB, stall, busy, wb_en, wb_reg, wb_data
  );
endinterface

// File: rtl/muldiv_scheduler.sv
// Runs one mul/div on the shared unit: latch operands, pulse start, wait for ready or timeout, write back once.
// Detect-to-writeback is 3 cycles plus unit delay; the core is held with stall until the writeback cycle.
module muldiv_scheduler #(
  parameter logic [4:0]  MULT_OP    = 5'b00110,
  parameter logic [4:0]  DIV_OP     = 5'b00111,
  parameter int          TIMEOUT    = 40,
  parameter logic [31:0] STATUS_MUL = 32'd4,
  parameter logic [31:0] STATUS_DIV = 32'd5
) (
  input logic               clock,
  input logic               reset,
  muldiv_scheduler_if.master bus
);
  localparam int              CNT_W      = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [4:0]      STATUS_REG = 5'd30;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  state_e           state_q, state_d;
  logic [31:0]      opa_q, opa_d;
  logic [31:0]      opb_q, opb_d;
  logic [31:0]      res_q, res_d;
  logic [4:0]       rd_q, rd_d;
  logic             is_div_q, is_div_d;
  logic             exc_q, exc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [4:0] alu_op;
  logic       detect;
  logic       unused_instr_bits;

  assign alu_op = bus.instruction[6:2];
  assign detect = (bus.instruction[31:27] == 5'b00000) &&
                  ((alu_op == MULT_OP) || (alu_op == DIV_OP));
  assign unused_instr_bits = ^{bus.instruction[21:7], bus.instruction[1:0]};

  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    res_d    = res_q;
    rd_d     = rd_q;
    is_div_d = is_div_q;
    exc_d    = exc_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (detect) begin
          opa_d    = bus.data_readRegA;
          opb_d    = bus.data_readRegB;
          rd_d     = bus.instruction[26:22];
          is_div_d = (alu_op == DIV_OP);
          cnt_d    = '0;
          state_d  = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // A ready arriving on the last allowed cycle still wins over the timeout.
        if (bus.unit_rdy) begin
          res_d   = bus.unit_result;
          exc_d   = bus.unit_exception;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          res_d   = '0;
          exc_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      res_q    <= '0;
      rd_q     <= '0;
      is_div_q <= 1'b0;
      exc_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      res_q    <= res_d;
      rd_q     <= rd_d;
      is_div_q <= is_div_d;
      exc_q    <= exc_d;
      cnt_q    <= cnt_d;
    end
  end

  // Only stall in IDLE looks at live inputs; it is gated so reset forces it low too.
  always_comb begin
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.stall         = 1'b0;
    bus.wb_en         = 1'b0;
    bus.wb_reg        = '0;
    bus.wb_data       = '0;
    bus.unit_operandA = opa_q;
    bus.unit_operandB = opb_q;
    bus.busy          = (state_q != IDLE);
    case (state_q)
      IDLE: bus.stall = detect & reset;
      ISSUE: begin
        bus.stall     = 1'b1;
        bus.ctrl_MULT = ~is_div_q;
        bus.ctrl_DIV  = is_div_q;
      end
      WAIT: bus.stall = 1'b1;
      DONE: begin
        if (exc_q) begin
          bus.wb_en   = 1'b1;
          bus.wb_reg  = STATUS_REG;
          bus.wb_data = is_div_q ? STATUS_DIV : STATUS_MUL;
        end else begin
          bus.wb_en   = (rd_q != 5'd0);
          bus.wb_reg  = rd_q;
          bus.wb_data = res_q;
        end
      end
      default: bus.stall = 1'b0;
    endcase
  end
endmodule
